laser_cover_sched: RTL

LASER_COVER_SCHED -- requirements
Module: laser_cover_sched

---
 rtl/laser_cover_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/laser_cover_sched.sv
// Two-circle coverage scheduler: buffers one frame of N_PTS target points, then
// counts for each candidate centre pair the points covered by either circle.
module laser_cover_sched #(
  parameter int unsigned N_PTS = 40,
  parameter int unsigned R2    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PT_VALID,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic       PT_READY,
  input  logic       RELOAD,
  input  logic       REQ_VALID,
  input  logic [3:0] REQ_C1X,
  input  logic [3:0] REQ_C1Y,
  input  logic [3:0] REQ_C2X,
  input  logic [3:0] REQ_C2Y,
  output logic       REQ_READY,
  output logic       RSP_VALID,
  output logic [5:0] RSP_COUNT,
  input  logic       RSP_READY,
  output logic       BUSY
);

  localparam int unsigned IW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_PTS - 1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EVAL, S_RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]    buf_x [N_PTS];
  logic [3:0]    buf_y [N_PTS];
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] idx;
  logic [5:0]    cnt;
  logic [5:0]    rsp_count;
  logic [3:0]    c1x, c1y, c2x, c2y;
  logic [8:0]    d1, d2;
  logic          hit;

  // Unsigned |a-b| per axis keeps the full 0..15 range (no modulo-16 wrap).
  function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                       input logic [3:0] bx, input logic [3:0] by);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    dx = (ax >= bx) ? ax - bx : bx - ax;
    dy = (ay >= by) ? ay - by : by - ay;
    sx = {4'b0, dx} * {4'b0, dx};
    sy = {4'b0, dy} * {4'b0, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  always_comb begin
    d1  = dist2(buf_x[idx], buf_y[idx], c1x, c1y);
    d2  = dist2(buf_x[idx], buf_y[idx], c2x, c2y);
    hit = (32'(d1) <= R2) || (32'(d2) <= R2);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LOAD: if (PT_VALID && wr_ptr == LAST) state_nxt = S_IDLE;
      S_IDLE: begin
        if (RELOAD)         state_nxt = S_LOAD;
        else if (REQ_VALID) state_nxt = S_EVAL;
      end
      S_EVAL: if (idx == LAST) state_nxt = S_RESP;
      S_RESP: if (RSP_READY) state_nxt = S_IDLE;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    PT_READY  = (state == S_LOAD);
    REQ_READY = (state == S_IDLE) && !RELOAD;
    RSP_VALID = (state == S_RESP);
    BUSY      = (state == S_EVAL) || (state == S_RESP);
    RSP_COUNT = rsp_count;
  end

  // Point storage carries no reset; a reset forces a full reload before use.
  always_ff @(posedge CLK) begin
    if (!RST && state == S_LOAD && PT_VALID) begin
      buf_x[wr_ptr] <= X;
      buf_y[wr_ptr] <= Y;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      idx       <= '0;
      cnt       <= '0;
      rsp_count <= '0;
      c1x       <= '0;
      c1y       <= '0;
      c2x       <= '0;
      c2y       <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (PT_VALID) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + IW'(1);
        end
        S_IDLE: begin
          if (RELOAD) begin
            wr_ptr <= '0;
          end else if (REQ_VALID) begin
            c1x <= REQ_C1X;
            c1y <= REQ_C1Y;
            c2x <= REQ_C2X;
            c2y <= REQ_C2Y;
            idx <= '0;
            cnt <= '0;
          end
        end
        S_EVAL: begin
          cnt <= cnt + {5'b0, hit};
          if (idx == LAST) begin
            idx       <= '0;
            rsp_count <= cnt + {5'b0, hit};
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
